// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: 640x480@60 defaults, counter widths and lock-FSM encodings.
// Used by both the VGA timing generator and the receive-side sync decoder.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  // Recovered coordinate and period counter widths
  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int HP_W  = 12;
  localparam int VP_W  = 10;

  // Lock FSM state encodings
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

endpackage

// File: rtl/sync_edge_det.sv
// Purpose: registers one sync/enable pin, normalises it to active-high, flags leading/trailing edges.
// Latency: lvl 1 cycle after the pin; lvl_d, lead and trail 2 cycles after the pin.
// Backpressure: none; free-running, samples the pin on every vga_clk.
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic lvl_d,
  output logic lead,
  output logic trail
);

  // Stage 1 captures the pin as "active", stage 2 is history; edge pulses are registered.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      lead  <= 1'b0;
      trail <= 1'b0;
    end else begin
      lvl   <= (din == POL);
      lvl_d <= lvl;
      lead  <= lvl & ~lvl_d;
      trail <= ~lvl & lvl_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Purpose: recovers pixel col/row from VGA syncs, measures line/frame periods, reports timing lock.
// Latency: line_start/frame_start/pix_valid/col 2 cycles after the pins; periods/lock 1 cycle later.
// Backpressure: none; pure monitor that observes the pins every vga_clk and never stalls.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic            h_sync,
  input  logic            v_sync,
  input  logic            disp_ena,
  output logic            pix_valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic            line_start,
  output logic            frame_start,
  output logic            locked,
  output logic [HP_W-1:0] h_period,
  output logic [VP_W-1:0] v_period,
  output logic            timing_err
);

  // Parameters zero-extended to the width of the counter they are compared with
  localparam logic [HP_W-1:0]  H_TOTAL_C  = HP_W'(H_TOTAL);
  localparam logic [COL_W:0]   H_ACTIVE_C = (COL_W + 1)'(H_ACTIVE);
  localparam logic [VP_W-1:0]  V_TOTAL_C  = VP_W'(V_TOTAL);
  localparam logic [ROW_W-1:0] V_ACTIVE_C = ROW_W'(V_ACTIVE);
  localparam logic [3:0]       LOCK_C     = 4'(LOCK_FRAMES);

  logic hs_lvl, hs_lvl_d, hs_trail;
  logic vs_lvl, vs_lvl_d, vs_trail;
  logic de_lvl, de_lvl_d, de_lead, de_trail;

  logic [HP_W-1:0] cyc_cnt;
  logic [VP_W-1:0] line_cnt;
  logic [VP_W-1:0] line_cnt_nxt;
  logic [COL_W:0]  pix_cnt;
  logic [1:0]      state;
  logic [3:0]      good_cnt;
  logic            frame_bad;
  logic            cyc_sat;
  logic            line_bad;
  logic            pix_bad;
  logic            hit_now;
  logic            frame_ok;

  sync_edge_det #(.POL(HS_POL)) u_hs_edge (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (h_sync),
    .lvl     (hs_lvl),
    .lvl_d   (hs_lvl_d),
    .lead    (line_start),
    .trail   (hs_trail)
  );

  sync_edge_det #(.POL(VS_POL)) u_vs_edge (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (v_sync),
    .lvl     (vs_lvl),
    .lvl_d   (vs_lvl_d),
    .lead    (frame_start),
    .trail   (vs_trail)
  );

  sync_edge_det #(.POL(1'b1)) u_de_edge (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (disp_ena),
    .lvl     (de_lvl),
    .lvl_d   (de_lvl_d),
    .lead    (de_lead),
    .trail   (de_trail)
  );

  // Only the edge pulses of the syncs are needed; sync levels and de_lead go unused.
  logic unused_edge_bits;
  assign unused_edge_bits = ^{hs_lvl, hs_lvl_d, hs_trail, vs_lvl, vs_lvl_d, vs_trail, de_lead};

  // The delayed enable lines up with col: col is cleared on the same edge that pix_valid rises.
  assign pix_valid = de_lvl_d;

  // Column: clear on the registered enable rising, count while it stays high, stick at all-ones.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      col <= '0;
    end else if (de_lvl && !de_lvl_d) begin
      col <= '0;
    end else if (de_lvl && (col != '1)) begin
      col <= col + COL_W'(1);
    end
  end

  // Row: one step per completed active line, restarted by every frame_start.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      row <= '0;
    end else if (frame_start) begin
      row <= '0;
    end else if (de_trail && (row != '1)) begin
      row <= row + ROW_W'(1);
    end
  end

  // Cycle counter measures hsync-to-hsync; restart at 1 so the latched value is the full period.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cyc_cnt  <= '0;
      h_period <= '0;
    end else if (line_start) begin
      cyc_cnt  <= HP_W'(1);
      h_period <= cyc_cnt;
    end else if (!cyc_sat) begin
      cyc_cnt  <= cyc_cnt + HP_W'(1);
    end
  end

  // A line_start coinciding with frame_start belongs to the frame that is ending.
  always_comb begin
    line_cnt_nxt = line_cnt;
    if (line_start && (line_cnt != '1)) begin
      line_cnt_nxt = line_cnt + VP_W'(1);
    end
  end

  // Line counter: latch lines-per-frame at each frame_start, then restart from zero.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      line_cnt <= '0;
      v_period <= '0;
    end else if (frame_start) begin
      line_cnt <= '0;
      v_period <= line_cnt_nxt;
    end else begin
      line_cnt <= line_cnt_nxt;
    end
  end

  // Per-cycle fault detection: wrong line length, lost hsync, or wrong active pixel count.
  always_comb begin
    cyc_sat  = (cyc_cnt == '1);
    pix_cnt  = {1'b0, col} + {{COL_W{1'b0}}, 1'b1};
    line_bad = (line_start && (cyc_cnt != H_TOTAL_C)) || cyc_sat;
    pix_bad  = de_trail && (pix_cnt != H_ACTIVE_C);
    hit_now  = line_bad || pix_bad;
    frame_ok = !frame_bad && !hit_now && (line_cnt_nxt == V_TOTAL_C) && (row == V_ACTIVE_C);
  end

  // Lock FSM: whole-frame verdicts at frame_start, immediate drop on any line fault once locked.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= ST_SEARCH;
      good_cnt   <= '0;
      frame_bad  <= 1'b0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      frame_bad  <= frame_start ? 1'b0 : (frame_bad || hit_now);
      case (state)
        ST_SEARCH: begin
          if (frame_start) begin
            state    <= ST_MEASURE;
            good_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (frame_start) begin
            if (!frame_ok) begin
              good_cnt <= '0;
            end else if ((good_cnt + 4'd1) == LOCK_C) begin
              state    <= ST_LOCKED;
              good_cnt <= '0;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (hit_now || (frame_start && !frame_ok)) begin
            state      <= ST_SEARCH;
            locked     <= 1'b0;
            timing_err <= 1'b1;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster (16x6 active inside 24x11 total).
// A second instance sees inverted syncs with HS_POL=VS_POL=1.
module tb_vga_sync_decoder;

  localparam int H_ACT    = 16;
  localparam int HFP      = 2;
  localparam int HSW      = 3;
  localparam int H_TOT    = 24;
  localparam int HS_START = H_ACT + HFP;
  localparam int V_ACT    = 6;
  localparam int VFP      = 1;
  localparam int VSW      = 2;
  localparam int V_TOT    = 11;
  localparam int VS_LINE  = V_ACT + VFP;
  localparam int RST_H    = 5;
  localparam int NT       = 5;

  logic vga_clk;
  logic reset;
  logic hs_a, vs_a, disp_ena;
  logic h_sync, v_sync, h_sync_p, v_sync_p;

  logic       pix_valid, line_start, frame_start, locked, timing_err;
  logic [9:0] col;
  logic [8:0] row;
  logic [11:0] h_period;
  logic [9:0] v_period;

  logic       pix_valid_p, line_start_p, frame_start_p, locked_p, timing_err_p;
  logic [9:0] col_p;
  logic [8:0] row_p;
  logic [11:0] h_period_p;
  logic [9:0] v_period_p;

  assign h_sync   = ~hs_a;
  assign v_sync   = ~vs_a;
  assign h_sync_p = hs_a;
  assign v_sync_p = vs_a;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .disp_ena(disp_ena),
    .pix_valid(pix_valid), .col(col), .row(row), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .h_period(h_period), .v_period(v_period),
    .timing_err(timing_err)
  );

  vga_sync_decoder #(
    .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)
  ) dut_pol (
    .vga_clk(vga_clk), .reset(reset), .h_sync(h_sync_p), .v_sync(v_sync_p), .disp_ena(disp_ena),
    .pix_valid(pix_valid_p), .col(col_p), .row(row_p), .line_start(line_start_p),
    .frame_start(frame_start_p), .locked(locked_p), .h_period(h_period_p), .v_period(v_period_p),
    .timing_err(timing_err_p)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Observation state
  int   ls_cnt = 0, fs_cnt = 0, err_cnt = 0;
  logic err_arm = 1'b0, hp_arm = 1'b0, ls_prev = 1'b0, rst_chk = 1'b0, mon_en = 1'b0;
  logic [31:0] err_hp = 0, err_lock = 0, cap_hp = 0;

  // What was driven one and two cycles ago
  logic q1_de = 1'b0, q2_de = 1'b0, q1_hsl = 1'b0, q2_hsl = 1'b0, q1_vsl = 1'b0, q2_vsl = 1'b0;
  int   q1_x = 0, q1_y = 0, q2_x = 0, q2_y = 0;

  // Pixels whose recovered coordinates are checked: (x, y, expected pix_valid)
  int tx[NT]  = '{5, 15, 0, 0, 16};
  int ty[NT]  = '{3, 5, 1, 0, 3};
  int tpv[NT] = '{1, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"},   pix_valid,   0);
    check({tag, "_col"},         col,         0);
    check({tag, "_row"},         row,         0);
    check({tag, "_line_start"},  line_start,  0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"},      locked,      0);
    check({tag, "_h_period"},    h_period,    0);
    check({tag, "_v_period"},    v_period,    0);
    check({tag, "_timing_err"},  timing_err,  0);
  endtask

  // One pixel clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic hs, input logic vs, input logic de,
                      input int x, input int y, input logic rst);
    @(negedge vga_clk);
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
    if (timing_err) begin
      err_cnt++;
      if (err_arm) begin
        err_arm  = 1'b0;
        err_hp   = 32'(h_period);
        err_lock = 32'(locked);
      end
    end
    if (hp_arm && ls_prev) begin
      hp_arm = 1'b0;
      cap_hp = 32'(h_period);
    end
    ls_prev = line_start;
    if (rst_chk) begin
      rst_chk = 1'b0;
      check_zero("mid_reset");
    end
    if (mon_en) begin
      for (int i = 0; i < NT; i++) begin
        if (q2_x == tx[i] && q2_y == ty[i]) begin
          check("coord_pix_valid", pix_valid, 32'(tpv[i]));
          if (tpv[i] != 0) begin
            check("coord_col", col, 32'(tx[i]));
            check("coord_row", row, 32'(ty[i]));
          end
        end
      end
      if (q2_hsl) check("line_start_latency", line_start, 1);
      if (q2_vsl) check("frame_start_latency", frame_start, 1);
    end
    q2_de  = q1_de;  q2_x = q1_x;  q2_y = q1_y;  q2_hsl = q1_hsl;  q2_vsl = q1_vsl;
    q1_de  = de;     q1_x = x;     q1_y = y;
    q1_hsl = hs & ~hs_a;
    q1_vsl = vs & ~vs_a;
    hs_a     = hs;
    vs_a     = vs;
    disp_ena = de;
    reset    = rst;
  endtask

  // One raster frame; optional shortened line and optional one-cycle reset pulse.
  task automatic frame(input int short_v, input int rst_v);
    for (int v = 0; v < V_TOT; v++) begin
      int len;
      len = (v == short_v) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        int lin;
        lin = (h >= HS_START) ? v : v - 1;
        if (v == rst_v && h == RST_H + 1) rst_chk = 1'b1;
        tick((h >= HS_START) && (h < HS_START + HSW),
             (lin >= VS_LINE) && (lin < VS_LINE + VSW),
             (h < H_ACT) && (v < V_ACT),
             h, v, (v == rst_v) && (h == RST_H));
      end
    end
  endtask

  initial begin
    reset = 1'b1; hs_a = 1'b0; vs_a = 1'b0; disp_ena = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 100, 100, 1'b1);
    check_zero("reset");

    // Nominal: lock on the third frame_start
    frame(-1, -1);
    frame(-1, -1);
    check("nom_locked_after_2", locked, 0);
    frame(-1, -1);
    check("nom_locked_after_3", locked, 1);
    check("nom_fs_count", fs_cnt, 3);
    check("nom_ls_count", ls_cnt, 3 * V_TOT);
    check("nom_h_period", h_period, H_TOT);
    check("nom_v_period", v_period, V_TOT);
    check("nom_err_count", err_cnt, 0);
    check("pol_locked", locked_p, 1);
    check("pol_h_period", h_period_p, H_TOT);
    check("pol_v_period", v_period_p, V_TOT);
    check("pol_err", timing_err_p, 0);

    // Coordinates and pulse latency in a locked frame
    mon_en = 1'b1;
    frame(-1, -1);
    mon_en = 1'b0;
    check("coord_locked", locked, 1);
    check("coord_err_count", err_cnt, 0);

    // One short line while locked
    err_cnt = 0;
    err_arm = 1'b1;
    frame(2, -1);
    check("short_err_count", err_cnt, 1);
    check("short_err_h_period", err_hp, H_TOT - 1);
    check("short_err_locked", err_lock, 0);
    check("short_locked_end", locked, 0);
    frame(-1, -1);
    check("relock_after_1", locked, 0);
    frame(-1, -1);
    check("relock_after_2", locked, 1);
    check("relock_err_count", err_cnt, 1);

    // Reset in the middle of a frame, then full relock sequence
    frame(-1, 3);
    check("rst_partial_locked", locked, 0);
    frame(-1, -1);
    check("rst_after_1", locked, 0);
    frame(-1, -1);
    check("rst_after_2", locked, 1);
    check("rst_v_period", v_period, V_TOT);

    // Sync loss: hsync held inactive long enough to saturate the cycle counter
    err_cnt = 0;
    repeat (5000) tick(1'b0, 1'b0, 1'b0, 100, 100, 1'b0);
    check("loss_locked", locked, 0);
    check("loss_err_count", err_cnt, 1);
    hp_arm = 1'b1;
    frame(-1, -1);
    check("loss_sat_h_period", cap_hp, 4095);
    check("loss_recover_h_period", h_period, H_TOT);
    check("loss_not_locked", locked, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
